// File: rtl/core_pkg.sv
// Shared core definitions: architectural register file geometry and the
// writeback entry carried through the long-latency result queue.
package core_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with a combinational head read.
// Pointers wrap naturally; count spans 0..DEPTH so full and empty are exact.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointer and occupancy bookkeeping; reset discards all queued entries.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count and the
    // pointers alone decide which slots hold live data.
    if (push) mem[wr_ptr] <= din;
  end

  // Upstream gating must never push into a full queue or pop an empty one.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("wb_fifo: push while full");
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty))
    else $error("wb_fifo: pop while empty");

endmodule

// File: rtl/wb_write_queue.sv
// Writeback driver for the register-file write port. Merges single-cycle ALU
// results with queued long-latency results (ALU has priority) and keeps a
// pending-destination scoreboard that decode uses to stall on hazards.
module wb_write_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic [31:0]   busy_vec,
  output logic          wb_wen,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_wdat
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     push_entry;
  wb_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          alu_fire;
  logic          push;
  logic          pop;
  logic [31:0]   busy_q;
  logic [31:0]   busy_next;

  // Writes to $zero are architecturally void, so they never claim the port.
  assign alu_fire = alu_valid && (alu_rd != REG_ZERO);

  // Full blocks acceptance even if the head drains this cycle (no bypass).
  assign lu_ready = !fifo_full;
  assign push     = lu_valid && lu_ready;

  // The queue drains only in cycles the ALU leaves the port free.
  assign pop = !alu_fire && !fifo_empty;

  assign push_entry.rd   = lu_rd;
  assign push_entry.data = lu_data;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_count_range: assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH))
    else $error("wb_write_queue: queue occupancy out of range");

  // Scoreboard next state: clear on pop into wb_*, then set on issue so a
  // same-register set/clear in one cycle leaves the register busy.
  always_comb begin
    // NOTE: default first so every path assigns busy_next and no latch forms.
    busy_next = busy_q;
    if (pop) busy_next[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != REG_ZERO)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  assign busy_vec = busy_q;
  assign rs_busy  = busy_q[rs];
  assign rt_busy  = busy_q[rt];

  // Registered write port: ALU first, then queue head; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_wdat <= '0;
    end else if (alu_fire) begin
      wb_wen  <= 1'b1;
      wb_rd   <= alu_rd;
      wb_wdat <= alu_data;
    end else if (pop) begin
      wb_wen  <= (head.rd != REG_ZERO);
      wb_rd   <= head.rd;
      wb_wdat <= head.data;
    end else begin
      wb_wen  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ref_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] busy_vec;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdat;

  // Reference model state.
  ref_entry_t  q[$];
  logic [31:0] exp_busy;
  logic        exp_wen;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wdat;

  int nvec = 0;
  int nerr = 0;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .busy_vec    (busy_vec),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_wdat     (wb_wdat)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lu_valid  = lv;  lu_rd  = lrd;  lu_data  = ld;
    issue_valid = iv; issue_rd = ird;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Advance the reference model by one clock from the current inputs, then
  // clock the DUT and return 1 time unit after the edge.
  task automatic step();
    ref_entry_t e;
    bit accept;
    accept = lu_valid && (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      exp_busy = '0;
      exp_wen  = 1'b0;
      exp_rd   = '0;
      exp_wdat = '0;
    end else begin
      if (alu_valid && alu_rd != 0) begin
        exp_wen = 1'b1; exp_rd = alu_rd; exp_wdat = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        exp_wen = (e.rd != 0); exp_rd = e.rd; exp_wdat = e.data;
        exp_busy[e.rd] = 1'b0;
      end else begin
        exp_wen = 1'b0;
      end
      if (accept) begin
        e.rd = lu_rd; e.data = lu_data;
        q.push_back(e);
      end
      if (issue_valid && issue_rd != 0) exp_busy[issue_rd] = 1'b1;
      exp_busy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rs = 5'd0; rt = 5'd0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    nvec++; if (wb_wen !== 1'b0) begin nerr++; $display("FAIL reset_wen got=%0b exp=0", wb_wen); end
    nvec++; if (wb_rd !== 5'd0) begin nerr++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    nvec++; if (wb_wdat !== 32'd0) begin nerr++; $display("FAIL reset_wdat got=%h exp=0", wb_wdat); end
    nvec++; if (busy_vec !== 32'd0) begin nerr++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    nvec++; if (lu_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%0b exp=1", lu_ready); end
    nvec++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin nerr++; $display("FAIL reset_rsrt got=%0b%0b exp=00", rs_busy, rt_busy); end
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd16, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'd16 || wb_wdat !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/16/deadbeef", wb_wen, wb_rd, wb_wdat);
    end
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    nvec++; if (wb_wen !== 1'b0) begin nerr++; $display("FAIL alu_zero_wen got=%0b exp=0", wb_wen); end
    nvec++; if (busy_vec !== 32'd0) begin nerr++; $display("FAIL alu_busy got=%h exp=0", busy_vec); end
    idle();
    step();
  endtask

  task automatic test_issue_lu();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step();
    rt = 5'd9;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h5, 1'b0, 5'd0);
    #1;
    nvec++; if (busy_vec[9] !== 1'b1) begin nerr++; $display("FAIL issue_busy9 got=%0b exp=1", busy_vec[9]); end
    nvec++; if (rt_busy !== 1'b1) begin nerr++; $display("FAIL issue_rt_busy got=%0b exp=1", rt_busy); end
    step();
    idle();
    step();
    nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'd9 || wb_wdat !== 32'h5) begin
      nerr++; $display("FAIL lu_write got=%0b/%0d/%h exp=1/9/5", wb_wen, wb_rd, wb_wdat);
    end
    nvec++; if (busy_vec[9] !== 1'b0 || rt_busy !== 1'b0) begin
      nerr++; $display("FAIL lu_clear9 got=%0b/%0b exp=0/0", busy_vec[9], rt_busy);
    end
    step();
  endtask

  task automatic test_alu_priority();
    logic [31:0] d [3];
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17);
    step();
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      drive(1'b1, 5'(i + 1), d[i], (i == 0), 5'd17, 32'hCAFE0017, 1'b0, 5'd0);
      step();
      nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'(i + 1) || wb_wdat !== d[i]) begin
        nerr++; $display("FAIL prio_alu%0d got=%0b/%0d/%h exp=1/%0d/%h", i, wb_wen, wb_rd, wb_wdat, i + 1, d[i]);
      end
      nvec++; if (busy_vec[17] !== 1'b1) begin nerr++; $display("FAIL prio_busy17_held%0d got=%0b exp=1", i, busy_vec[17]); end
    end
    idle();
    step();
    nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'd17 || wb_wdat !== 32'hCAFE0017) begin
      nerr++; $display("FAIL prio_lu got=%0b/%0d/%h exp=1/17/cafe0017", wb_wen, wb_rd, wb_wdat);
    end
    nvec++; if (busy_vec[17] !== 1'b0) begin nerr++; $display("FAIL prio_clear17 got=%0b exp=0", busy_vec[17]); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd5, 32'(i), 1'b1, 5'(24 + i), 32'hF000 + 32'(i), 1'b0, 5'd0);
      step();
    end
    drive(1'b1, 5'd5, 32'd99, 1'b1, 5'd28, 32'hBAD, 1'b0, 5'd0);
    #1;
    nvec++; if (lu_ready !== 1'b0) begin nerr++; $display("FAIL full_ready got=%0b exp=0", lu_ready); end
    step();
    nvec++; if (lu_ready !== 1'b0) begin nerr++; $display("FAIL full_ready_hold got=%0b exp=0", lu_ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'(24 + i) || wb_wdat !== 32'hF000 + 32'(i)) begin
        nerr++; $display("FAIL full_drain%0d got=%0b/%0d/%h exp=1/%0d/%h", i, wb_wen, wb_rd, wb_wdat, 24 + i, 32'hF000 + 32'(i));
      end
      nvec++; if (lu_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_back%0d got=%0b exp=1", i, lu_ready); end
    end
    step();
    nvec++; if (wb_wen !== 1'b0) begin nerr++; $display("FAIL full_fifth_dropped got=%0b rd=%0d exp=0", wb_wen, wb_rd); end
  endtask

  task automatic test_set_clear();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA, 1'b0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
    step();
    nvec++; if (wb_wen !== 1'b1 || wb_rd !== 5'd10) begin nerr++; $display("FAIL setclr_pop got=%0b/%0d exp=1/10", wb_wen, wb_rd); end
    nvec++; if (busy_vec[10] !== 1'b1) begin nerr++; $display("FAIL setclr_busy10 got=%0b exp=1", busy_vec[10]); end
    idle();
    step();
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 32'd7, 1'b1, 5'(11 + i), 32'(i), 1'b0, 5'd0);
      step();
    end
    nvec++; if (busy_vec[8] !== 1'b1) begin nerr++; $display("FAIL mid_busy8 got=%0b exp=1", busy_vec[8]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    nvec++; if (busy_vec !== 32'd0 || lu_ready !== 1'b1) begin
      nerr++; $display("FAIL mid_reset got=%h/%0b exp=0/1", busy_vec, lu_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++; if (wb_wen !== 1'b0) begin nerr++; $display("FAIL mid_no_write%0d got=%0b rd=%0d exp=0", i, wb_wen, wb_rd); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 45), 5'($urandom), $urandom,
            ($urandom_range(0, 99) < 55), 5'($urandom), $urandom,
            ($urandom_range(0, 99) < 30), 5'($urandom));
      rs = 5'($urandom);
      rt = 5'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      #1;
      nvec++; if (lu_ready !== (q.size() < DEPTH)) begin
        nerr++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, lu_ready, q.size() < DEPTH);
      end
      nvec++; if (rs_busy !== exp_busy[rs] || rt_busy !== exp_busy[rt]) begin
        nerr++; $display("FAIL rnd_rsrt n=%0d got=%0b%0b exp=%0b%0b", n, rs_busy, rt_busy, exp_busy[rs], exp_busy[rt]);
      end
      step();
      nvec++; if (wb_wen !== exp_wen || wb_rd !== exp_rd || wb_wdat !== exp_wdat) begin
        nerr++; $display("FAIL rnd_wb n=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", n, wb_wen, wb_rd, wb_wdat, exp_wen, exp_rd, exp_wdat);
      end
      nvec++; if (busy_vec !== exp_busy) begin
        nerr++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy_vec, exp_busy);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    exp_busy = '0; exp_wen = 1'b0; exp_rd = '0; exp_wdat = '0;
    test_reset();
    test_alu();
    test_issue_lu();
    test_alu_priority();
    test_full();
    test_set_clear();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writeback-side driver of the register-file write port (wen/rd/wdat). It merges two result producers into one write per cycle:
  - single-cycle ALU results;
  - long-latency results (load/mul-div) arriving with a valid/ready handshake.
- Holds a 32-bit pending-destination scoreboard so decode can stall on rs/rt hazards.
- Sits between the execute/memory units and the register file in the RISC core.

Parameters:
- DEPTH, 4, entries in the long-latency result FIFO (power of 2, ≥2)
- AW, 5, register address width (32 architectural registers)
- DW, 32, data width

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  queue can accept (= !full)
- lu_rd  in  AW  long-latency destination
- lu_data  in  DW  long-latency result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  AW  its destination (marks busy)
- rs  in  AW  decode source 1
- rt  in  AW  decode source 2
- rs_busy  out  1  rs has a pending long-latency write
- rt_busy  out  1  rt has a pending long-latency write
- busy_vec  out  32  full scoreboard
- wb_wen  out  1  register-file write enable (registered)
- wb_rd  out  AW  register-file write address (registered)
- wb_wdat  out  DW  register-file write data (registered)

Behaviour:
- Reset (rst=1 at posedge):
  - wb_wen=0, wb_rd=0, wb_wdat=0.
  - FIFO empty; head/tail pointers=0, count=0.
  - busy_vec=0, so rs_busy=rt_busy=0 and lu_ready=1.
  - Any queued or in-flight data is discarded.
- ALU write request: alu_fire = alu_valid && alu_rd!=0. ALU writes to $zero are dropped and do not occupy the port.
- Write port, one write per cycle with 1-cycle latency:
  - If alu_fire: next wb_wen=1, wb_rd=alu_rd, wb_wdat=alu_data.
  - Else if FIFO non-empty: pop head; next wb_wen = (head.rd!=0), wb_rd=head.rd, wb_wdat=head.data.
  - Else: wb_wen=0; wb_rd/wb_wdat hold their previous values.
- Priority: ALU always wins. The FIFO drains only in cycles without alu_fire. There is no starvation guard; upstream issue rate bounds it.
- Push: lu_valid && lu_ready, written at tail. lu_ready = (count != DEPTH), combinational from count only. When full, lu_ready=0 even if a pop happens the same cycle (no bypass).
- Simultaneous push and pop when non-full: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Pushes are never into a full FIFO. Popping an empty FIFO is impossible by construction; an assertion must flag either.
- Ordering: long-latency results are written in arrival order. There is no ordering between ALU and FIFO entries; the decode stall guarantees no conflict.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at posedge.
  - Clear: busy[rd] clears at the posedge where a FIFO entry with that rd is popped into wb_* (same edge wb_wen rises).
  - If set and clear hit the same register in the same cycle, set wins.
  - ALU writes never touch the scoreboard.
  - busy[0] is always 0.
- rs_busy=busy_vec[rs] and rt_busy=busy_vec[rt], combinational. A register stays busy until its write is visible on wb_* (the register file commits one edge later); decode stalls for that extra cycle.
- The block does not detect or resolve ALU writes to a busy register; that is an upstream contract.

Decomposition:
- Shared package (core_pkg): REG_AW=5, DATA_W=32, REG_ZERO=0, and a wb_entry_t struct {rd, data}.
- One natural sub-module: wb_fifo, a parameterised sync FIFO with push/pop/full/empty/count.
- The arbiter and scoreboard stay in the top module.

Test Plan:
- Reset → wb_wen=0, busy_vec=0, lu_ready=1. Reset again mid-stream with 3 entries queued and busy[8]=1 → empty FIFO, busy_vec=0 next cycle, no further wb_wen.
- ALU only: alu_valid=1, rd=16, data=0xDEADBEEF → next cycle wb_wen=1, wb_rd=16, wb_wdat=0xDEADBEEF. Same with rd=0 → wb_wen=0.
- Issue rd=9, then lu push rd=9 data=0x5 with ALU idle → busy[9]=1 from the issue edge; rt=9 gives rt_busy=1; one cycle after the push, wb_wen=1, wb_rd=9, busy[9]=0.
- ALU priority: ALU active 3 cycles while lu pushes rd=17 → FIFO write is delayed until the first ALU-idle cycle, then appears. All ALU writes emerge in order and unaltered.
- Full: ALU held active and 4 lu pushes → lu_ready=0, and a 5th offer is not accepted. When ALU goes idle, entries drain one per cycle in push order; lu_ready returns 1 the cycle after the first pop.
- Same-cycle set/clear: popping an entry with rd=10 while issue_rd=10 → busy[10] stays 1.
